// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run controller.
//   - run_state_e       : controller FSM state encoding
//   - DEF_END_PC        : default lowest PC at which a zero instruction ends a run
//   - DEF_DRAIN_CYCLES  : default number of enabled cycles after end detection
//   - DEF_MAX_CYCLES    : default run-cycle limit (timeout build only)
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_DRAIN,
        ST_DUMP,
        ST_DONE
    } run_state_e;

    localparam int unsigned DEF_END_PC       = 22;
    localparam int unsigned DEF_DRAIN_CYCLES = 5;
    localparam int unsigned DEF_MAX_CYCLES   = 2000;

endpackage

// File: rtl/rf_dump_seq.sv
// Register-file dump sequencer: walks indices 0..REG_NUM-1 over a
// valid/ready port. One idle cycle separates start_i from the first beat.
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   clear_i  in   clear index and handshake state
//   start_i  in   begin a dump from index 0
//   ready_i  in   consumer accepts the current beat
//   valid_o  out  beat valid (registered)
//   idx_o    out  index of the current beat (registered)
//   last_o   out  pulse: final beat transfers this cycle
module rf_dump_seq #(
    parameter int unsigned REG_NUM   = 32,
    parameter int unsigned ADDR_SIZE = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [ADDR_SIZE-1:0] idx_o,
    output logic                 last_o
);

    localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(REG_NUM - 1);

    logic                 pend_q, pend_d;
    logic                 valid_q, valid_d;
    logic [ADDR_SIZE-1:0] idx_q, idx_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            pend_q  <= pend_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        pend_d  = pend_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        if (clear_i) begin
            pend_d  = 1'b0;
            valid_d = 1'b0;
            idx_d   = '0;
        end else if (start_i) begin
            pend_d  = 1'b1;
            valid_d = 1'b0;
            idx_d   = '0;
        end else begin
            if (pend_q) begin
                valid_d = 1'b1;
                pend_d  = 1'b0;
            end
            // Index and valid only move on a completed transfer, so the
            // payload is held while the consumer stalls.
            if (valid_q && ready_i) begin
                if (idx_q == LAST_IDX) begin
                    valid_d = 1'b0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end
    end

    assign valid_o = valid_q;
    assign idx_o   = idx_q;
    assign last_o  = valid_q && ready_i && (idx_q == LAST_IDX);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Hardware run controller for the 5-stage CPU. Launches a run from PC 0,
// gates the pipeline enable, detects end-of-program (first unsquashed zero
// instruction fetched at or beyond END_PC), drains the pipeline for
// DRAIN_CYCLES enabled cycles, then streams the register file out.
// Optional build macro: CPU_RUN_CTRL_TIMEOUT_EN (run-cycle limit MAX_CYCLES).
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-low reset
//   start       in   begin a run from IDLE or DONE
//   step        in   single enabled cycle from IDLE
//   halt_req    in   force end of run (RUN only)
//   f_pc        in   fetch-stage PC
//   f_inst      in   fetch-stage instruction
//   ex_taken    in   EX redirect (fetched instruction squashed)
//   cpu_en      out  pipeline advance enable
//   cpu_rst     out  one-cycle CPU restart
//   rf_rd_addr  out  regfile read address
//   rf_rd_data  in   combinational regfile read data
//   dump_valid  out  dump beat valid
//   dump_idx    out  register index of beat
//   dump_data   out  register value (follows rf_rd_data)
//   dump_ready  in   consumer accepts beat
//   busy        out  run in progress
//   done        out  dump complete
//   timeout     out  run ended by cycle limit
//   cycles      out  RUN cycles in current run (saturating)
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned REG_NUM      = 32,
    parameter int unsigned ADDR_SIZE    = 5,
    parameter int unsigned PC_BITS      = 5,
    parameter int unsigned END_PC       = DEF_END_PC,
    parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int unsigned MAX_CYCLES   = DEF_MAX_CYCLES,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 step,
    input  logic                 halt_req,
    input  logic [PC_BITS-1:0]   f_pc,
    input  logic [XLEN-1:0]      f_inst,
    input  logic                 ex_taken,
    output logic                 cpu_en,
    output logic                 cpu_rst,
    output logic [ADDR_SIZE-1:0] rf_rd_addr,
    input  logic [XLEN-1:0]      rf_rd_data,
    output logic                 dump_valid,
    output logic [ADDR_SIZE-1:0] dump_idx,
    output logic [XLEN-1:0]      dump_data,
    input  logic                 dump_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_W-1:0]     cycles
);

    localparam int unsigned DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    run_state_e       state_q, state_d;
    logic             cpu_en_q, cpu_en_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             timeout_q, timeout_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             seq_clear, seq_start, seq_last;
    logic             seq_valid;
    logic [ADDR_SIZE-1:0] seq_idx;

    logic             end_hit;
    logic [CNT_W-1:0] cycles_inc;
    logic             limit_hit;

    assign end_hit    = (f_pc >= PC_BITS'(END_PC)) && (f_inst == '0) && !ex_taken;
    assign cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);

`ifdef CPU_RUN_CTRL_TIMEOUT_EN
    assign limit_hit = (cycles_inc >= CNT_W'(MAX_CYCLES));
`else
    logic unused_max_cycles;
    assign unused_max_cycles = (MAX_CYCLES == 0);
    assign limit_hit         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cpu_en_q  <= 1'b0;
            cpu_rst_q <= 1'b0;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cpu_en_q  <= cpu_en_d;
            cpu_rst_q <= cpu_rst_d;
            cycles_q  <= cycles_d;
            timeout_q <= timeout_d;
            drain_q   <= drain_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Registered outputs are computed from the next state so they line up
    // with the state they describe.
    always_comb begin
        state_d   = state_q;
        cpu_en_d  = 1'b0;
        cpu_rst_d = 1'b0;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;
        drain_d   = drain_q;
        seq_clear = 1'b0;
        seq_start = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_LAUNCH;
                    cpu_rst_d = 1'b1;
                    cycles_d  = '0;
                    timeout_d = 1'b0;
                    seq_clear = 1'b1;
                end else if (step && (state_q == ST_IDLE)) begin
                    cpu_en_d = 1'b1;
                end
            end
            ST_LAUNCH: begin
                state_d  = ST_RUN;
                cpu_en_d = 1'b1;
            end
            ST_RUN: begin
                cpu_en_d = 1'b1;
                cycles_d = cycles_inc;
                if (limit_hit) begin
                    timeout_d = 1'b1;
                end
                if (end_hit || halt_req || limit_hit) begin
                    state_d = ST_DRAIN;
                    drain_d = DW'(DRAIN_CYCLES);
                end
            end
            ST_DRAIN: begin
                // Entered with DRAIN_CYCLES loaded; enable stays high until
                // the counter is exhausted, then the dump is armed.
                if (drain_q <= DW'(1)) begin
                    state_d   = ST_DUMP;
                    seq_start = 1'b1;
                end else begin
                    drain_d  = drain_q - DW'(1);
                    cpu_en_d = 1'b1;
                end
            end
            ST_DUMP: begin
                if (seq_last) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    rf_dump_seq #(
        .REG_NUM   (REG_NUM),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_dump_seq (
        .clk     (clk),
        .rst     (rst),
        .clear_i (seq_clear),
        .start_i (seq_start),
        .ready_i (dump_ready),
        .valid_o (seq_valid),
        .idx_o   (seq_idx),
        .last_o  (seq_last)
    );

    assign cpu_en     = cpu_en_q;
    assign cpu_rst    = cpu_rst_q;
    assign cycles     = cycles_q;
    assign timeout    = timeout_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign dump_valid = seq_valid;
    assign dump_idx   = seq_idx;
    assign rf_rd_addr = seq_idx;
    // Gated so the port reads zero outside a beat, including under reset.
    assign dump_data  = seq_valid ? rf_rd_data : '0;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a small fetch model and regfile sit beside the
// controller; expected dump beats are queued when a run is launched and a
// monitor pops and compares them on every transfer.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, step, halt_req;
    logic [4:0]  f_pc;
    logic [31:0] f_inst;
    logic        ex_taken;
    logic        cpu_en, cpu_rst;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        dump_valid;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        dump_ready;
    logic        busy, done, timeout;
    logic [15:0] cycles;

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .XLEN(32), .REG_NUM(32), .ADDR_SIZE(5), .PC_BITS(5),
        .END_PC(22), .DRAIN_CYCLES(5), .MAX_CYCLES(2000), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .step(step), .halt_req(halt_req),
        .f_pc(f_pc), .f_inst(f_inst), .ex_taken(ex_taken),
        .cpu_en(cpu_en), .cpu_rst(cpu_rst),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data),
        .dump_ready(dump_ready), .busy(busy), .done(done),
        .timeout(timeout), .cycles(cycles)
    );

    // Regfile model with combinational read.
    logic [31:0] rf [32];
    assign rf_rd_data = rf[rf_rd_addr];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Free-running counters observed by the main sequence as differences.
    int cyc = 0, en_cnt = 0, rst_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cpu_en)  en_cnt  <= en_cnt + 1;
        if (cpu_rst) rst_cnt <= rst_cnt + 1;
    end

    // Fetch model: PC restarts on cpu_rst, advances on cpu_en, redirects to
    // 20 when EX reports a taken branch. Only PC 22 holds a zero word.
    logic [7:0] pc_q;
    logic       squashed;
    bit         no_end = 1'b0;
    bit         squash_mode = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= '0; squashed <= 1'b0;
        end else if (cpu_rst) begin
            pc_q <= '0; squashed <= 1'b0;
        end else if (cpu_en) begin
            if (ex_taken) begin
                pc_q <= 8'd20; squashed <= 1'b1;
            end else begin
                pc_q <= pc_q + 8'd1;
            end
        end
    end
    assign f_pc     = pc_q[4:0];
    assign f_inst   = (!no_end && pc_q == 8'd22) ? 32'h0 : 32'h0000_0013;
    assign ex_taken = squash_mode && (pc_q == 8'd22) && !squashed;

    // Scoreboard
    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;
    beat_t       exp_q[$];
    beat_t       exp_b;
    int          xfer_cnt = 0;
    logic        hold_v = 1'b0;
    logic [4:0]  hold_idx;
    logic [31:0] hold_data;

    always @(negedge clk) begin
        if (!rst || !dump_valid) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("stall_idx", {59'd0, dump_idx}, {59'd0, hold_idx});
                check("stall_data", {32'd0, dump_data}, {32'd0, hold_data});
            end
            if (dump_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_beat: got idx %0d, required no beat", dump_idx);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("beat_idx", {59'd0, dump_idx}, {59'd0, exp_b.idx});
                    check("beat_data", {32'd0, dump_data}, {32'd0, exp_b.data});
                end
                xfer_cnt++;
                hold_v = 1'b0;
            end else begin
                hold_v    = 1'b1;
                hold_idx  = dump_idx;
                hold_data = dump_data;
            end
        end
    end

    // Stimulus helpers
    bit       toggle_mode = 1'b0;
    logic [3:0] pat = 4'b1001;   // ready sequence 1,0,0,1
    int       k = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
        dump_ready = toggle_mode ? pat[k % 4] : 1'b1;
    endtask

    task automatic push_all();
        beat_t b;
        for (int i = 0; i < 32; i++) begin
            b.idx  = 5'(i);
            b.data = rf[i];
            exp_q.push_back(b);
        end
    endtask

    task automatic do_start(output int n0);
        start = 1'b1;
        tick();
        start = 1'b0;
        n0 = cyc;
    endtask

    task automatic wait_valid(input int n0, input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            if (dump_valid) begin lat = cyc - n0; break; end
            tick();
        end
    endtask

    task automatic wait_done(input int n0, input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin lat = cyc - n0; break; end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, lat, e0, r0, x0;
        bit hit;
        rst = 1'b0; start = 1'b0; step = 1'b0; halt_req = 1'b0; dump_ready = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = 32'hC0DE_0000 + 32'(i) * 32'h0101;
        #12;
        check("rst_cpu_en",  {63'd0, cpu_en}, 64'd0);
        check("rst_cpu_rst", {63'd0, cpu_rst}, 64'd0);
        check("rst_valid",   {63'd0, dump_valid}, 64'd0);
        check("rst_busy",    {63'd0, busy}, 64'd0);
        check("rst_done",    {63'd0, done}, 64'd0);
        check("rst_timeout", {63'd0, timeout}, 64'd0);
        check("rst_cycles",  {48'd0, cycles}, 64'd0);
        check("rst_idx",     {59'd0, dump_idx}, 64'd0);
        check("rst_addr",    {59'd0, rf_rd_addr}, 64'd0);
        check("rst_data",    {32'd0, dump_data}, 64'd0);
        rst = 1'b1;
        tick(); tick();

        // Three single steps from IDLE
        e0 = en_cnt; r0 = rst_cnt;
        for (int s = 0; s < 3; s++) begin
            step = 1'b1; tick(); step = 1'b0;
            check("step_busy", {63'd0, busy}, 64'd0);
            tick(); tick();
        end
        check("step_en_count", 64'(en_cnt - e0), 64'd3);
        check("step_no_rst",   64'(rst_cnt - r0), 64'd0);
        check("step_cycles",   {48'd0, cycles}, 64'd0);
        check("step_done",     {63'd0, done}, 64'd0);

        // Normal run, zero at PC 22, ready held high
        push_all();
        x0 = xfer_cnt; e0 = en_cnt; r0 = rst_cnt;
        do_start(n0);
        wait_valid(n0, 100, lat);
        check("run1_valid_latency", 64'(lat), 64'd30);
        wait_done(n0, 200, lat);
        check("run1_done_latency", 64'(lat), 64'd62);
        check("run1_cycles",   {48'd0, cycles}, 64'd23);
        check("run1_en_count", 64'(en_cnt - e0), 64'd28);
        check("run1_rst_pulse", 64'(rst_cnt - r0), 64'd1);
        check("run1_xfers",    64'(xfer_cnt - x0), 64'd32);
        check("run1_queue",    64'(exp_q.size()), 64'd0);
        check("run1_busy",     {63'd0, busy}, 64'd0);
        check("run1_cpu_en",   {63'd0, cpu_en}, 64'd0);
        check("run1_timeout",  {63'd0, timeout}, 64'd0);
        halt_req = 1'b1; tick(); halt_req = 1'b0; tick();
        check("halt_outside_run", {63'd0, done}, 64'd1);

        // Squashed zero at PC 22, redirect to 20, ready toggling 1,0,0,1
        for (int i = 0; i < 32; i++) rf[i] = 32'h5A00_0000 ^ (32'(i) << 8) ^ 32'h77;
        squash_mode = 1'b1; toggle_mode = 1'b1;
        push_all();
        x0 = xfer_cnt;
        do_start(n0);
        wait_valid(n0, 100, lat);
        check("run2_valid_latency", 64'(lat), 64'd33);
        wait_done(n0, 400, lat);
        check("run2_done",   {63'd0, done}, 64'd1);
        check("run2_cycles", {48'd0, cycles}, 64'd26);
        check("run2_xfers",  64'(xfer_cnt - x0), 64'd32);
        check("run2_queue",  64'(exp_q.size()), 64'd0);
        squash_mode = 1'b0; toggle_mode = 1'b0; dump_ready = 1'b1;

        // Endless program stopped by halt_req at cycle 50
        no_end = 1'b1;
        push_all();
        x0 = xfer_cnt;
        do_start(n0);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cycles == 16'd50) begin hit = 1'b1; break; end
            tick();
        end
        check("halt_reached_50", {63'd0, hit}, 64'd1);
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        wait_done(n0, 300, lat);
        check("halt_done",    {63'd0, done}, 64'd1);
        check("halt_cycles",  {48'd0, cycles}, 64'd51);
        check("halt_timeout", {63'd0, timeout}, 64'd0);
        check("halt_xfers",   64'(xfer_cnt - x0), 64'd32);

`ifdef CPU_RUN_CTRL_TIMEOUT_EN
        // Endless program stopped by the cycle limit
        push_all();
        x0 = xfer_cnt;
        do_start(n0);
        wait_done(n0, 2300, lat);
        check("to_done",    {63'd0, done}, 64'd1);
        check("to_timeout", {63'd0, timeout}, 64'd1);
        check("to_cycles",  {48'd0, cycles}, 64'd2000);
        check("to_xfers",   64'(xfer_cnt - x0), 64'd32);
`endif
        no_end = 1'b0;

        // Async reset at beat 10 of a dump, then a fresh run
        push_all();
        x0 = xfer_cnt;
        do_start(n0);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (xfer_cnt - x0 >= 10) begin hit = 1'b1; break; end
            tick();
        end
        check("mid_reached_10", {63'd0, hit}, 64'd1);
        check("mid_idx", {59'd0, dump_idx}, 64'd10);
        #2 rst = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_cpu_en", {63'd0, cpu_en}, 64'd0);
        check("mid_rst_valid",  {63'd0, dump_valid}, 64'd0);
        check("mid_rst_busy",   {63'd0, busy}, 64'd0);
        check("mid_rst_done",   {63'd0, done}, 64'd0);
        check("mid_rst_data",   {32'd0, dump_data}, 64'd0);
        check("mid_rst_cycles", {48'd0, cycles}, 64'd0);
        check("mid_rst_xfers",  64'(xfer_cnt - x0), 64'd10);
        tick();
        rst = 1'b1;
        tick();
        push_all();
        x0 = xfer_cnt;
        do_start(n0);
        wait_done(n0, 200, lat);
        check("rerun_done_latency", 64'(lat), 64'd62);
        check("rerun_xfers", 64'(xfer_cnt - x0), 64'd32);
        check("rerun_queue", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
